lsu_ctrl: RTL

- Load/store access stage, directly downstream of address generation.
- Takes the already-computed effective address and byte enables, then issues one data-memory transaction over a valid/ready request channel and waits for the response.
- Returns aligned, sign- or zero-extended load data, or a bus access-fault exception, to writeback.
- Stalls the pipeline while a transaction is outstanding. At most one transaction is in flight.

---
 rtl/lsu_ctrl_if.sv | 23 ++
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl_if.sv
// Data-memory request/response channel between the LSU and the bus.
// The master drives requests; the slave returns one response per request.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wstrb, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store stage: issues one data-memory transaction per op,
// formats load data and reports bus access faults to writeback.
module lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            op_valid,
  input  logic            op_load,
  input  logic            op_store,
  input  logic [2:0]      op_size,
  input  logic [XLEN-1:0] op_addr,
  input  logic [3:0]      op_ben,
  input  logic [XLEN-1:0] op_sdata,
  input  logic            flush,
  lsu_ctrl_if.master      bus,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] ldata,
  output logic            exception,
  output logic [3:0]      ecause,
  output logic [XLEN-1:0] etval
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state, state_nx;

  logic            accept;
  logic            complete;
  logic            kill;
  logic            kill_now;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      ben_q;
  logic [2:0]      size_q;
  logic            store_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_fmt;
  logic [XLEN-1:0] ldata_fmt;
  logic [7:0]      lb;
  logic [15:0]     lh;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    complete      = 1'b0;
    stall         = 1'b0;
    bus.req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid && (op_load || op_store) && !flush) begin
          accept   = 1'b1;
          stall    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus.req_valid = 1'b1;
        if (bus.req_ready) state_nx = RESP;
      end
      RESP: begin
        stall = 1'b1;
        if (bus.resp_valid) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_write = bus.req_valid & store_q;
  assign bus.req_addr  = bus.req_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.req_wstrb = (bus.req_valid && store_q) ? ben_q : 4'b0;
  assign bus.req_wdata = (bus.req_valid && store_q) ? wdata_q : '0;

  always_comb begin
    wdata_fmt = op_sdata;
    unique case (op_size[1:0])
      2'd0:    wdata_fmt = {4{op_sdata[7:0]}};
      2'd1:    wdata_fmt = {2{op_sdata[15:0]}};
      default: wdata_fmt = op_sdata;
    endcase
  end

  assign lb = bus.resp_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lh = addr_q[1] ? bus.resp_rdata[31:16] : bus.resp_rdata[15:0];

  always_comb begin
    ldata_fmt = bus.resp_rdata;
    unique case (size_q)
      3'd0:    ldata_fmt = {{24{lb[7]}}, lb};
      3'd1:    ldata_fmt = {{16{lh[15]}}, lh};
      3'd4:    ldata_fmt = {24'b0, lb};
      3'd5:    ldata_fmt = {16'b0, lh};
      default: ldata_fmt = bus.resp_rdata;
    endcase
    if (store_q || bus.resp_error) ldata_fmt = '0;
  end

  // A flush landing in the response cycle itself still kills the result.
  assign kill_now = kill | flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      ben_q   <= '0;
      size_q  <= '0;
      store_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= op_addr;
      ben_q   <= op_ben;
      size_q  <= op_size;
      store_q <= op_store;
      wdata_q <= wdata_fmt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kill      <= 1'b0;
      done      <= 1'b0;
      ldata     <= '0;
      exception <= 1'b0;
      ecause    <= '0;
      etval     <= '0;
    end else begin
      done <= complete & ~kill_now;
      if (complete) kill <= 1'b0;
      else if (state != IDLE && flush) kill <= 1'b1;
      if (complete && !kill_now) begin
        ldata     <= ldata_fmt;
        exception <= bus.resp_error;
        ecause    <= bus.resp_error ? (store_q ? 4'd7 : 4'd5) : 4'd0;
        etval     <= bus.resp_error ? addr_q : '0;
      end
    end
  end

endmodule
